// File: rtl/trade_pkg.sv
// Shared constants and state type for the Z-score sequencing path.
package trade_pkg;

   localparam int ZS_DATA_W = 8;
   localparam int ZS_FRAC_W = 4;
   localparam int ZS_CNT_W  = 8;

   // Z-score width and its saturated value for the default configuration
   localparam int                Z_W   = ZS_DATA_W + ZS_FRAC_W;
   localparam logic [Z_W-1:0]    Z_MAX = {Z_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VAR    = 3'd1,
      ST_SQRT   = 3'd2,
      ST_DIV    = 3'd3,
      ST_DECIDE = 3'd4
   } zs_state_t;

endpackage

// File: rtl/shift_sub_unit.sv
// One restoring shift-subtract step: compare the already-shifted partial
// remainder with the trial operand, subtract when it fits, emit the result bit.
module shift_sub_unit #(
   parameter int IN_W  = 11,
   parameter int OUT_W = 9
) (
   input  logic [IN_W-1:0]  i_rem,
   input  logic [IN_W-1:0]  i_sub,
   output logic [OUT_W-1:0] o_rem,
   output logic             o_bit
);

   // Trial subtraction; the restored remainder always fits in OUT_W bits
   always_comb begin
      o_bit = (i_rem >= i_sub);
      if (o_bit) begin
         o_rem = OUT_W'(i_rem - i_sub);
      end else begin
         o_rem = OUT_W'(i_rem);
      end
   end

endmodule

// File: rtl/zscore_scheduler.sv
// Z-score sequencer: variance, bitwise square root and fixed-point divide on
// one shared shift-subtract step, then a one-cycle buy/sell decision.
module zscore_scheduler
   import trade_pkg::*;
#(
   parameter int DATA_W = ZS_DATA_W,
   parameter int FRAC_W = ZS_FRAC_W,
   parameter int CNT_W  = ZS_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     sample_valid,
   input  logic [DATA_W-1:0]        current_data,
   input  logic [DATA_W-1:0]        mean,
   input  logic [2*DATA_W-1:0]      sqr_mean,
   input  logic [DATA_W+FRAC_W-1:0] z_thresh,
   output logic                     busy,
   output logic                     z_valid,
   output logic [DATA_W+FRAC_W-1:0] z_mag,
   output logic                     buy_signal,
   output logic                     sell_signal,
   output logic [CNT_W-1:0]         dropped_cnt
);

   localparam int ZW   = DATA_W + FRAC_W;
   localparam int SS_W = DATA_W + 3;   // shifted remainder width seen by the step unit
   localparam int RM_W = DATA_W + 1;   // stored remainder width
   localparam int IT_W = $clog2(ZW);
   localparam logic [IT_W-1:0] SQ_LAST = IT_W'(DATA_W - 1);
   localparam logic [IT_W-1:0] DV_LAST = IT_W'(ZW - 1);

   zs_state_t             r_state;
   logic [DATA_W-1:0]     r_cur;
   logic [DATA_W-1:0]     r_mean;
   logic [2*DATA_W-1:0]   r_sqr;
   logic [ZW-1:0]         r_thr;
   logic [2*DATA_W-1:0]   r_var;
   logic [DATA_W-1:0]     r_diff;
   logic                  r_dir;
   logic [DATA_W-1:0]     r_sd;
   logic [RM_W-1:0]       r_rem;
   logic [ZW-1:0]         r_quo;
   logic [ZW-1:0]         r_dvd;
   logic [IT_W-1:0]       r_cnt;
   logic                  r_busy;
   logic                  r_z_valid;
   logic [ZW-1:0]         r_z_mag;
   logic                  r_buy;
   logic                  r_sell;
   logic [CNT_W-1:0]      r_drop;

   logic [2*DATA_W-1:0]   w_msq;
   logic [2*DATA_W:0]     w_var_full;
   logic [DATA_W-1:0]     w_diff;
   logic                  w_dir;
   logic [SS_W-1:0]       w_ss_in;
   logic [SS_W-1:0]       w_ss_sub;
   logic [RM_W-1:0]       w_ss_rem;
   logic                  w_ss_bit;
   logic                  w_fire;
   logic                  w_accept;
   logic                  w_drop;

   // Variance with sign bit, absolute deviation and direction from latched stats
   always_comb begin
      w_msq      = {{DATA_W{1'b0}}, r_mean} * {{DATA_W{1'b0}}, r_mean};
      w_var_full = {1'b0, r_sqr} - {1'b0, w_msq};
      w_dir      = (r_cur > r_mean);
      if (w_dir) begin
         w_diff = r_cur - r_mean;
      end else begin
         w_diff = r_mean - r_cur;
      end
      w_fire = (r_quo >= r_thr) && (r_diff != {DATA_W{1'b0}});
   end

   // Operand select for the shared step: root trial in SQRT, divisor in DIV
   always_comb begin
      if (r_state == ST_SQRT) begin
         w_ss_in  = {r_rem, r_var[2*DATA_W-1 -: 2]};
         w_ss_sub = {1'b0, r_quo[DATA_W-1:0], 2'b01};
      end else begin
         w_ss_in  = {1'b0, r_rem, r_dvd[ZW-1]};
         w_ss_sub = {{(SS_W-DATA_W){1'b0}}, r_sd};
      end
   end

   shift_sub_unit #(
      .IN_W  (SS_W),
      .OUT_W (RM_W)
   ) u_step (
      .i_rem (w_ss_in),
      .i_sub (w_ss_sub),
      .o_rem (w_ss_rem),
      .o_bit (w_ss_bit)
   );

   // Acceptance only from IDLE with enable; any other offered sample is a drop
   always_comb begin
      w_accept = (r_state == ST_IDLE) && enable;
      w_drop   = sample_valid && !w_accept;
   end

   // Main sequencer: latches a sample, iterates the datapath, registers the decision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cur     <= {DATA_W{1'b0}};
         r_mean    <= {DATA_W{1'b0}};
         r_sqr     <= {(2*DATA_W){1'b0}};
         r_thr     <= {ZW{1'b0}};
         r_var     <= {(2*DATA_W){1'b0}};
         r_diff    <= {DATA_W{1'b0}};
         r_dir     <= 1'b0;
         r_sd      <= {DATA_W{1'b0}};
         r_rem     <= {RM_W{1'b0}};
         r_quo     <= {ZW{1'b0}};
         r_dvd     <= {ZW{1'b0}};
         r_cnt     <= {IT_W{1'b0}};
         r_busy    <= 1'b0;
         r_z_valid <= 1'b0;
         r_z_mag   <= {ZW{1'b0}};
         r_buy     <= 1'b0;
         r_sell    <= 1'b0;
      end else begin
         r_z_valid <= 1'b0;
         r_buy     <= 1'b0;
         r_sell    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sample_valid && enable) begin
                  r_cur   <= current_data;
                  r_mean  <= mean;
                  r_sqr   <= sqr_mean;
                  r_thr   <= z_thresh;
                  r_busy  <= 1'b1;
                  r_state <= ST_VAR;
               end
            end
            ST_VAR: begin
               if (w_var_full[2*DATA_W]) begin
                  r_var <= {(2*DATA_W){1'b0}};
               end else begin
                  r_var <= w_var_full[2*DATA_W-1:0];
               end
               r_diff  <= w_diff;
               r_dir   <= w_dir;
               r_rem   <= {RM_W{1'b0}};
               r_quo   <= {ZW{1'b0}};
               r_cnt   <= {IT_W{1'b0}};
               r_state <= ST_SQRT;
            end
            ST_SQRT: begin
               r_rem <= w_ss_rem;
               r_quo <= {r_quo[ZW-2:0], w_ss_bit};
               r_var <= {r_var[2*DATA_W-3:0], 2'b00};
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == SQ_LAST) begin
                  r_sd    <= {r_quo[DATA_W-2:0], w_ss_bit};
                  r_rem   <= {RM_W{1'b0}};
                  r_quo   <= {ZW{1'b0}};
                  r_dvd   <= {r_diff, {FRAC_W{1'b0}}};
                  r_cnt   <= {IT_W{1'b0}};
                  r_state <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (r_sd == {DATA_W{1'b0}}) begin
                  // Zero spread: any deviation saturates the score
                  if (r_diff != {DATA_W{1'b0}}) begin
                     r_quo <= {ZW{1'b1}};
                  end else begin
                     r_quo <= {ZW{1'b0}};
                  end
                  r_state <= ST_DECIDE;
               end else begin
                  r_rem <= w_ss_rem;
                  r_quo <= {r_quo[ZW-2:0], w_ss_bit};
                  r_dvd <= {r_dvd[ZW-2:0], 1'b0};
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == DV_LAST) begin
                     r_state <= ST_DECIDE;
                  end
               end
            end
            ST_DECIDE: begin
               r_z_mag   <= r_quo;
               r_z_valid <= 1'b1;
               r_sell    <= r_dir && w_fire;
               r_buy     <= !r_dir && w_fire;
               r_busy    <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Saturating count of refused samples
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drop <= {CNT_W{1'b0}};
      end else if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
         r_drop <= r_drop + 1'b1;
      end
   end

   assign busy        = r_busy;
   assign z_valid     = r_z_valid;
   assign z_mag       = r_z_mag;
   assign buy_signal  = r_buy;
   assign sell_signal = r_sell;
   assign dropped_cnt = r_drop;

endmodule

// File: tb/tb_zscore_scheduler.sv
// Self-checking bench for zscore_scheduler against an arithmetic reference model.
module tb_zscore_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        sample_valid;
   logic [7:0]  current_data;
   logic [7:0]  mean;
   logic [15:0] sqr_mean;
   logic [11:0] z_thresh;
   logic        busy;
   logic        z_valid;
   logic [11:0] z_mag;
   logic        buy_signal;
   logic        sell_signal;
   logic [7:0]  dropped_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_drop = 0;

   zscore_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .sample_valid (sample_valid),
      .current_data (current_data),
      .mean         (mean),
      .sqr_mean     (sqr_mean),
      .z_thresh     (z_thresh),
      .busy         (busy),
      .z_valid      (z_valid),
      .z_mag        (z_mag),
      .buy_signal   (buy_signal),
      .sell_signal  (sell_signal),
      .dropped_cnt  (dropped_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the statistics
   function automatic void ref_model(input int cur, input int mn, input int sq, input int thr,
                                     output int z, output int lat, output int buy, output int sell);
      int v, sd, d;
      v = sq - mn * mn;
      if (v < 0) v = 0;
      sd = 0;
      while ((sd + 1) * (sd + 1) <= v) sd++;
      d = (cur > mn) ? cur - mn : mn - cur;
      if (sd == 0) begin
         z   = (d != 0) ? 4095 : 0;
         lat = 12;
      end else begin
         z   = (d * 16) / sd;
         lat = 23;
      end
      buy  = (cur < mn && z >= thr) ? 1 : 0;
      sell = (cur > mn && z >= thr) ? 1 : 0;
   endfunction

   // Offer one sample for a single cycle and check the resulting pulse
   task automatic run_sample(input int cur, input int mn, input int sq, input int thr, input string tag);
      int z, lat, eb, es, seen, last_busy;
      ref_model(cur, mn, sq, thr, z, lat, eb, es);
      @(negedge clk);
      current_data = 8'(cur);
      mean         = 8'(mn);
      sqr_mean     = 16'(sq);
      z_thresh     = 12'(thr);
      enable       = 1'b1;
      sample_valid = 1'b1;
      @(posedge clk);
      seen      = 0;
      last_busy = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin
            sample_valid = 1'b0;
            check_eq({tag, ".busy_c1"}, int'(busy), 1);
         end
         if (z_valid) begin
            seen = c;
            break;
         end
         last_busy = int'(busy);
      end
      check_eq({tag, ".pulse_cycle"}, seen, lat);
      if (seen != 0) begin
         check_eq({tag, ".z_mag"}, int'(z_mag), z);
         check_eq({tag, ".buy"}, int'(buy_signal), eb);
         check_eq({tag, ".sell"}, int'(sell_signal), es);
         check_eq({tag, ".busy_pulse"}, int'(busy), 0);
         check_eq({tag, ".busy_decide"}, last_busy, 1);
         @(negedge clk);
         check_eq({tag, ".one_cycle"}, int'(z_valid | buy_signal | sell_signal), 0);
         check_eq({tag, ".z_hold"}, int'(z_mag), z);
      end
   endtask

   initial begin
      int pulses, p_first, p_second, mn, cur, sq, thr;
      rst          = 1'b0;
      enable       = 1'b0;
      sample_valid = 1'b0;
      current_data = 8'd0;
      mean         = 8'd0;
      sqr_mean     = 16'd0;
      z_thresh     = 12'd0;
      repeat (3) @(negedge clk);
      check_eq("reset.busy", int'(busy), 0);
      check_eq("reset.z_valid", int'(z_valid), 0);
      check_eq("reset.z_mag", int'(z_mag), 0);
      check_eq("reset.signals", int'(buy_signal | sell_signal), 0);
      check_eq("reset.drop", int'(dropped_cnt), 0);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases
      run_sample(110, 100, 10025, 32'h020, "basic_sell");
      run_sample(90,  100, 10025, 32'h020, "basic_buy");
      run_sample(100, 100, 10025, 32'h020, "no_signal");
      run_sample(101, 100, 9990,  32'h020, "clamp_sat");
      run_sample(110, 100, 10030, 32'h020, "thresh_eq");
      run_sample(110, 100, 10030, 32'h021, "thresh_above");
      run_sample(100, 100, 10000, 32'h000, "zero_zero");
      check_eq("directed.drop", int'(dropped_cnt), exp_drop);

      // Held sample_valid: accepts at 0 and 23, 28 drops
      @(negedge clk);
      current_data = 8'd110;
      mean         = 8'd100;
      sqr_mean     = 16'd10025;
      z_thresh     = 12'h020;
      enable       = 1'b1;
      sample_valid = 1'b1;
      pulses   = 0;
      p_first  = 0;
      p_second = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 30) sample_valid = 1'b0;
         if (z_valid) begin
            pulses++;
            if (pulses == 1) p_first = c;
            if (pulses == 2) p_second = c;
         end
      end
      exp_drop += 28;
      check_eq("hold.first_pulse", p_first, 23);
      check_eq("hold.second_pulse", p_second, 46);
      check_eq("hold.drop", int'(dropped_cnt), exp_drop);

      // Reset in the middle of a computation
      @(negedge clk);
      current_data = 8'd90;
      sample_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) sample_valid = 1'b0;
      end
      rst = 1'b0;
      exp_drop = 0;
      #1;
      check_eq("midrst.busy", int'(busy), 0);
      check_eq("midrst.z_mag", int'(z_mag), 0);
      check_eq("midrst.pulse", int'(z_valid | buy_signal | sell_signal), 0);
      check_eq("midrst.drop", int'(dropped_cnt), 0);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (z_valid | buy_signal | sell_signal) pulses++;
      end
      check_eq("midrst.no_pulse", pulses, 0);
      run_sample(90, 100, 10025, 32'h020, "after_rst");

      // Enable gating
      @(negedge clk);
      enable       = 1'b0;
      sample_valid = 1'b1;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         pulses += int'(busy);
      end
      sample_valid = 1'b0;
      exp_drop += 5;
      check_eq("enable.no_busy", pulses, 0);
      check_eq("enable.drop", int'(dropped_cnt), exp_drop);

      // Randomized samples
      for (int i = 0; i < 40; i++) begin
         mn  = int'($urandom_range(0, 255));
         cur = int'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            sq = int'($urandom_range(0, 65535));
         end else begin
            sq = mn * mn + int'($urandom_range(0, 700)) - 100;
         end
         if (sq < 0) sq = 0;
         if (sq > 65535) sq = 65535;
         thr = int'($urandom_range(0, 300));
         run_sample(cur, mn, sq, thr, $sformatf("rand%0d", i));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      check_eq("rand.drop", int'(dropped_cnt), exp_drop);

      // Drop counter saturation
      @(negedge clk);
      enable       = 1'b0;
      sample_valid = 1'b1;
      repeat (300) @(negedge clk);
      sample_valid = 1'b0;
      check_eq("drop.saturate", int'(dropped_cnt), 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/zscore_scheduler.md
# zscore_scheduler

Sequencing controller for the trading Z-score path. It takes one windowed statistics sample at a time: current price, N-sample mean and mean of squares from the preprocessor. It then drives a multi-cycle computation over a single shared shift-subtract engine: variance, integer square root, then fixed-point divide. It issues one-cycle buy/sell decisions and sits between the preprocessor and the order-side logic.

## Interface
- `DATA_W`, 8: width of price and mean samples.
- `FRAC_W`, 4: fractional bits of the Z-score (Q(DATA_W).FRAC_W).
- `CNT_W`, 8: width of the dropped-sample counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `enable`  in  1  when 0, no new sample is accepted; an in-flight computation still completes.
- `sample_valid`  in  1  statistics sample present this cycle.
- `current_data`  in  DATA_W  latest price.
- `mean`  in  DATA_W  windowed mean.
- `sqr_mean`  in  2*DATA_W  windowed mean of squares.
- `z_thresh`  in  DATA_W+FRAC_W  decision threshold, Q format as z.
- `busy`  out  1  computation in flight.
- `z_valid`  out  1  one-cycle pulse: `z_mag` / decision valid.
- `z_mag`  out  DATA_W+FRAC_W  |current−mean|/stddev, Q format.
- `buy_signal`  out  1  one-cycle pulse with `z_valid`.
- `sell_signal`  out  1  one-cycle pulse with `z_valid`.
- `dropped_cnt`  out  CNT_W  saturating count of refused samples.

## Operation
- **States:** IDLE, VAR, SQRT, DIV, DECIDE.
- **IDLE:** if `sample_valid && enable`, latch the three inputs and `z_thresh`, then go to VAR. The threshold is held constant for the whole computation.
- **VAR:** compute `var = sqr_mean − mean*mean` in 2*DATA_W+1 bits. A negative result clamps to 0. Compute `diff = |current−mean|` and `dir` (1 if current > mean).
- **SQRT:** restoring bitwise integer sqrt, DATA_W iterations, one per cycle. Result `stddev = floor(sqrt(var))`.
- **DIV:**
  - If `stddev == 0`, skip the iterations. Set z = max (all ones) when diff ≠ 0, else z = 0.
  - Otherwise run a restoring divide of `diff << FRAC_W` by `stddev`, DATA_W+FRAC_W iterations, one per cycle. The quotient is truncated.
- **DECIDE:** register `z_mag` and assert `z_valid`.
  - `sell_signal` = `dir && z >= thresh && diff != 0`.
  - `buy_signal` = `!dir && z >= thresh && diff != 0`.
  - buy and sell are never both 1.
  - Then return to IDLE.
- SQRT and DIV share one shift-subtract datapath, selected by state.
- **Drops:** every cycle with `sample_valid == 1` that is not accepted (busy, or `enable == 0`) increments `dropped_cnt`. The counter saturates at all ones.

## Timing
- **Reset:** all outputs 0, state IDLE. `z_mag` holds its last value between pulses, and resets to 0.
- **Asynchronous reset mid-computation:** abandon the computation and emit no pulse. `dropped_cnt` clears.
- **Cycle numbering:** the accept cycle is cycle 0. VAR is cycle 1, SQRT cycles 2..(1+DATA_W), DIV the next DATA_W+FRAC_W cycles, then DECIDE.
- **Defaults:** DECIDE is cycle 22. `z_valid`, `buy_signal` and `sell_signal` are high during cycle 23, one cycle only.
- **Zero-stddev path:** DIV takes 1 cycle, so the pulse appears in cycle 12.
- **busy:** high from cycle 1 through DECIDE inclusive. It is low in the pulse cycle, so a new sample can be accepted in cycle 23.
- **Throughput:** at best one sample per 23 cycles.
- **Simultaneous events:** `sample_valid` arriving in the same cycle as the pulse is accepted, not dropped.

## Structure
- **Package `trade_pkg`:**
  - `DATA_W` and `FRAC_W` defaults.
  - Z width constant and `Z_MAX`.
  - The `zs_state_t` enum.
- **Sub-module `shift_sub_unit`:** a one-iteration restoring step (remainder/operand in, next remainder and bit out). It is instantiated once and shared by the SQRT and DIV states.
- **Top level:** FSM, operand registers, iteration counter, drop counter.

## Test plan
- **Basic sell:** mean=100, sqr_mean=10025, current=110, thresh=0x020. Expect var=25, stddev=5, z_mag=0x020, `sell_signal`=1 and `buy_signal`=0, pulse in cycle 23.
- **Buy and no-signal:** same stats with current=90 gives `buy_signal`=1. With current=100, z_mag=0 and neither signal fires, but `z_valid`=1.
- **Clamp and saturation:** sqr_mean=9990, mean=100, current=101. Variance clamps to 0, z_mag=0xFFF, `sell_signal`=1, pulse in cycle 12.
- **Sqrt floor and threshold equality:** var=30 gives stddev=5. With diff=10, z=0x020 and thresh=0x020, fire. With thresh=0x021, no signal.
- **Drop counting:** hold `sample_valid` high for 30 cycles from idle. Expect accepts at cycles 0 and 23 and `dropped_cnt`=28.
- **Reset mid-computation and enable gating:** deassert `rst` in cycle 10. Expect no pulse, all outputs 0, and a new sample accepted normally after release. With `enable`=0, samples are refused and counted.
